// File: rtl/compressed_sample_buffer_if.sv
// compressed_sample_buffer_if: compressor capture inputs and codec-side replay outputs
interface compressed_sample_buffer_if #(parameter int DEPTH = 8);
   logic start, in_done, clear_flags;
   logic signed [11:0] in_sample;
   logic signed [11:0] sample_out;
   logic sample_strobe, overflow, underflow;
   logic [$clog2(DEPTH):0] fifo_count;
   modport master (
      output start, in_sample, in_done, clear_flags,
      input sample_out, sample_strobe, fifo_count, overflow, underflow
   );
   modport slave (
      input start, in_sample, in_done, clear_flags,
      output sample_out, sample_strobe, fifo_count, overflow, underflow
   );
endinterface

// File: rtl/compressed_sample_buffer.sv
// compressed_sample_buffer: captures one compressor result per start and replays at a fixed sample cadence
module compressed_sample_buffer #(
   parameter int SAMPLING_RATE = 24000,
   parameter int CLOCK_FREQ = 27000000,
   parameter int DEPTH = 8
) (
   input logic clock,
   input logic reset_n,
   compressed_sample_buffer_if.slave bus
);
   localparam int DIV = CLOCK_FREQ / SAMPLING_RATE;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(DIV);
   logic [DW-1:0] div_cnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic armed, push_pend;
   logic signed [11:0] push_data;
   logic signed [11:0] mem [DEPTH];
   logic tick, empty, full, pop_ok, push_ok;
   always_comb begin
      tick = div_cnt == DW'(DIV - 1);
      empty = count == '0;
      full = count == CW'(DEPTH);
      pop_ok = tick & ~empty;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      push_ok = push_pend & (~full | tick);
   end
   assign bus.fifo_count = count;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
         armed <= 1'b0;
         push_pend <= 1'b0;
         push_data <= '0;
         bus.sample_out <= '0;
         bus.sample_strobe <= 1'b0;
         bus.overflow <= 1'b0;
         bus.underflow <= 1'b0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DW'(1);
         armed <= bus.start | (armed & ~bus.in_done);
         push_pend <= armed & bus.in_done;
         push_data <= bus.in_sample;
         wr_ptr <= wr_ptr + AW'(push_ok);
         rd_ptr <= rd_ptr + AW'(pop_ok);
         count <= count + CW'(push_ok) - CW'(pop_ok);
         bus.sample_strobe <= tick;
         bus.sample_out <= pop_ok ? mem[rd_ptr] : bus.sample_out;
         bus.overflow <= (push_pend & full & ~tick) | (bus.overflow & ~bus.clear_flags);
         bus.underflow <= (tick & empty) | (bus.underflow & ~bus.clear_flags);
      end
   end
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end
endmodule

// File: tb/tb_compressed_sample_buffer.sv
// tb_compressed_sample_buffer: directed scenarios plus randomized traffic against a queue-based model
module tb_compressed_sample_buffer;
   localparam int CF = 240000;
   localparam int SR = 24000;
   localparam int DEPTH = 4;
   localparam int DIV = CF / SR;
   logic clock = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;
   compressed_sample_buffer_if #(.DEPTH(DEPTH)) bus ();
   compressed_sample_buffer #(.SAMPLING_RATE(SR), .CLOCK_FREQ(CF), .DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus)
   );
   logic [11:0] so;
   assign so = bus.sample_out;
   int checks = 0;
   int failures = 0;
   int k = 0;
   int strobes = 0;
   logic [11:0] q[$];
   bit armed, pend, m_str, m_ovf, m_unf;
   logic [11:0] pend_val, m_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit tick, o_set, u_set;
      @(posedge clock);
      tick = (k % DIV) == DIV - 1;
      o_set = 0;
      u_set = 0;
      if (tick) begin
         if (q.size() > 0) m_out = q.pop_front();
         else u_set = 1;
      end
      if (pend) begin
         if (q.size() < DEPTH) q.push_back(pend_val);
         else o_set = 1;
      end
      pend = armed && bus.in_done;
      pend_val = bus.in_sample;
      armed = bus.start ? 1'b1 : (pend ? 1'b0 : armed);
      m_ovf = o_set | (m_ovf & !bus.clear_flags);
      m_unf = u_set | (m_unf & !bus.clear_flags);
      m_str = tick;
      k++;
      @(negedge clock);
      check("model_sample_out", so, m_out);
      check("model_strobe", bus.sample_strobe, m_str);
      check("model_count", bus.fifo_count, q.size());
      check("model_overflow", bus.overflow, m_ovf);
      check("model_underflow", bus.underflow, m_unf);
      if (bus.sample_strobe) strobes++;
   endtask

   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      check("rst_sample_out", so, 0);
      check("rst_strobe", bus.sample_strobe, 0);
      check("rst_count", bus.fifo_count, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_underflow", bus.underflow, 0);
      q.delete();
      armed = 0; pend = 0; pend_val = 0; m_out = 0; m_str = 0; m_ovf = 0; m_unf = 0;
      k = 0;
      strobes = 0;
      bus.start = 0; bus.in_done = 0; bus.in_sample = 0; bus.clear_flags = 0;
      #1 reset_n = 1'b1;
   endtask

   initial begin
      bus.start = 0; bus.in_done = 0; bus.in_sample = 0; bus.clear_flags = 0;
      // basic capture and replay
      do_reset();
      bus.start = 1; cycle();
      bus.start = 0; cycle(); cycle();
      bus.in_done = 1; bus.in_sample = 12'h7F0; cycle();
      bus.in_done = 0; cycle();
      check("s1_count_after_push", bus.fifo_count, 1);
      repeat (5) cycle();
      check("s1_first_strobe", bus.sample_strobe, 1);
      check("s1_strobe_count", strobes, 1);
      check("s1_out", so, 12'h7F0);
      check("s1_count_drained", bus.fifo_count, 0);
      // held done pushes once
      do_reset();
      bus.start = 1; cycle();
      bus.start = 0; bus.in_done = 1; bus.in_sample = 12'hFFB;
      repeat (3) cycle();
      check("s2_one_push", bus.fifo_count, 1);
      repeat (47) cycle();
      check("s2_no_second", bus.fifo_count, 0);
      check("s2_out", so, 12'hFFB);
      check("s2_underflow", bus.underflow, 1);
      bus.in_done = 0;
      // underflow and clear
      do_reset();
      repeat (9) cycle();
      check("s3_no_early_unf", bus.underflow, 0);
      cycle();
      check("s3_unf_at_10", bus.underflow, 1);
      repeat (15) cycle();
      check("s3_strobes", strobes, 2);
      check("s3_out_zero", so, 0);
      bus.clear_flags = 1; cycle();
      bus.clear_flags = 0;
      check("s3_cleared", bus.underflow, 0);
      // overflow
      do_reset();
      for (int i = 0; i < 6; i++) begin
         bus.start = i < 5; bus.in_done = i > 0; bus.in_sample = 12'(i);
         cycle();
      end
      bus.start = 0; bus.in_done = 0; cycle();
      check("s4_full", bus.fifo_count, 4);
      check("s4_overflow", bus.overflow, 1);
      repeat (3) cycle();
      check("s4_replay_1", so, 1);
      for (int n = 2; n <= 4; n++) begin
         repeat (10) cycle();
         check("s4_replay", so, n);
      end
      repeat (10) cycle();
      check("s4_no_5", so, 4);
      check("s4_unf", bus.underflow, 1);
      // full FIFO push on tick
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.start = i < 4; bus.in_done = i > 0; bus.in_sample = 12'(i + 8);
         cycle();
      end
      bus.start = 0; bus.in_done = 0; cycle(); cycle();
      bus.start = 1; cycle();
      bus.start = 0; bus.in_done = 1; bus.in_sample = 12'h055; cycle();
      bus.in_done = 0; cycle();
      check("s5a_strobe", bus.sample_strobe, 1);
      check("s5a_count", bus.fifo_count, 4);
      check("s5a_no_ovf", bus.overflow, 0);
      check("s5a_out", so, 9);
      // empty FIFO push on tick
      do_reset();
      repeat (7) cycle();
      bus.start = 1; cycle();
      bus.start = 0; bus.in_done = 1; bus.in_sample = 12'h123; cycle();
      bus.in_done = 0; cycle();
      check("s5b_unf", bus.underflow, 1);
      check("s5b_count", bus.fifo_count, 1);
      repeat (10) cycle();
      check("s5b_strobe", bus.sample_strobe, 1);
      check("s5b_out", so, 12'h123);
      // async reset mid-stream
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.start = i < 3; bus.in_done = i > 0; bus.in_sample = 12'(i + 12'h40);
         cycle();
      end
      bus.start = 0; bus.in_done = 0; cycle();
      check("s6_count3", bus.fifo_count, 3);
      bus.start = 1; cycle();
      bus.start = 0;
      do_reset();
      bus.in_done = 1; bus.in_sample = 12'h3FF;
      repeat (9) cycle();
      check("s6_no_early_strobe", strobes, 0);
      cycle();
      check("s6_strobe_10", bus.sample_strobe, 1);
      check("s6_ignored_done", bus.fifo_count, 0);
      check("s6_out", so, 0);
      bus.in_done = 0;
      // randomized traffic
      do_reset();
      repeat (800) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         bus.start = $urandom_range(0, 5) == 0;
         bus.in_done = 1'($urandom_range(0, 1));
         bus.in_sample = 12'($urandom);
         bus.clear_flags = $urandom_range(0, 30) == 0;
         cycle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
